// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a byte producer and the PS/2 host transmitter.
//   iVALID/iDATA  producer offers a command byte
//   oREADY        transmitter idle and able to accept
//   oDONE/oERR    one-cycle completion pulses, oERR_CODE qualifies oERR
interface ps2_host_tx_if;
    logic       iVALID;
    logic [7:0] iDATA;
    logic       oREADY;
    logic       oDONE;
    logic       oERR;
    logic [1:0] oERR_CODE;
    modport master (output iVALID, iDATA, input oREADY, oDONE, oERR, oERR_CODE);
    modport slave  (input iVALID, iDATA, output oREADY, oDONE, oERR, oERR_CODE);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from host to a PS/2 device (inhibit, request, bit clocking, ACK check).
//   iCLK_50, iRST_n        single clock, asynchronous active-low reset
//   cmd (slave)            command handshake and done/error pulses
//   ps2_clk_i, ps2_dat_i   raw line levels
//   ps2_clk_oe, ps2_dat_oe 1 pulls the line low, 0 releases it
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 4
) (
    input  logic              iCLK_50,
    input  logic              iRST_n,
    ps2_host_tx_if.slave      cmd,
    input  logic              ps2_clk_i,
    input  logic              ps2_dat_i,
    output logic              ps2_clk_oe,
    output logic              ps2_dat_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK_WAIT, RELEASE_WAIT, DONE, ERR} state_t;

    state_t             state_q, state_d;
    logic [1:0]         s1_q, s2_q, filt_q, filt_d;
    logic [1:0][FW-1:0] flt_cnt_q, flt_cnt_d;
    logic [IW-1:0]      inh_q, inh_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic [1:0]         code_q, code_d;
    logic               fall, timed, send_low;

    // bit 0 = clock line, bit 1 = data line; a level is accepted after
    // FILTER_LEN consecutive synchronized samples disagree with the current one
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        for (int i = 0; i < 2; i++)
            if (s2_q[i] != filt_q[i]) begin
                flt_cnt_d[i] = flt_cnt_q[i] + 1'b1;
                if (flt_cnt_q[i] == FLT_LAST) begin
                    filt_d[i]    = s2_q[i];
                    flt_cnt_d[i] = '0;
                end
            end
    end

    assign fall  = filt_q[0] & ~filt_d[0];
    assign timed = state_q inside {REQ, SEND, ACK_WAIT, RELEASE_WAIT};
    // idx 0..7 data LSB first, 8 parity (odd, so pull low when byte has odd weight), 9 stop
    assign send_low = idx_q < 4'd8 ? ~data_q[idx_q[2:0]] : (idx_q == 4'd8) & (^data_q);

    always_comb begin
        state_d = state_q;
        inh_d   = '0;
        idx_d   = idx_q;
        data_d  = data_q;
        code_d  = code_q;
        tmo_d   = (timed && !fall) ? tmo_q + 1'b1 : '0;
        case (state_q)
            IDLE:         if (cmd.iVALID) begin
                              state_d = INHIBIT;
                              data_d  = cmd.iDATA;
                          end
            INHIBIT:      if (inh_q == INH_LAST) state_d = REQ;
                          else inh_d = inh_q + 1'b1;
            REQ:          if (fall) begin
                              state_d = SEND;
                              idx_d   = '0;
                          end
            SEND:         if (fall) begin
                              if (idx_q == 4'd9) state_d = ACK_WAIT;
                              else idx_d = idx_q + 1'b1;
                          end
            ACK_WAIT:     if (fall) begin
                              state_d = filt_q[1] ? ERR : RELEASE_WAIT;
                              if (filt_q[1]) code_d = 2'b10;
                          end
            RELEASE_WAIT: if (&filt_q) state_d = DONE;
            default:      state_d = IDLE;
        endcase
        if (timed && !fall && tmo_q == TMO_LAST) begin
            state_d = ERR;
            code_d  = 2'b01;
        end
    end

    always_ff @(posedge iCLK_50 or negedge iRST_n)
        if (!iRST_n) begin
            state_q   <= IDLE;
            s1_q      <= '1;
            s2_q      <= '1;
            filt_q    <= '1;
            flt_cnt_q <= '0;
            inh_q     <= '0;
            tmo_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            s1_q      <= {ps2_dat_i, ps2_clk_i};
            s2_q      <= s1_q;
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
            inh_q     <= inh_d;
            tmo_q     <= tmo_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            code_q    <= code_d;
        end

    // line drivers decode the asynchronously reset state, so reset releases them at once
    assign ps2_clk_oe    = state_q == INHIBIT;
    assign ps2_dat_oe    = state_q == REQ || (state_q == SEND && send_low);
    assign cmd.oREADY    = state_q == IDLE;
    assign cmd.oDONE     = state_q == DONE;
    assign cmd.oERR      = state_q == ERR;
    assign cmd.oERR_CODE = code_q;
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, meaning clock-inhibit duration in iCLK_50 cycles (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, meaning maximum cycles allowed between device clock falling edges, and for the request phase (15 ms).
REQ-003 Parameter FILTER_LEN, default 4, meaning consecutive equal synchronized samples required to accept a new PS/2 line level.
REQ-004 iCLK_50  input  1  system clock, 50 MHz; the block uses this single clock.
REQ-005 iRST_n  input  1  reset, asynchronous, active-low.
REQ-006 iVALID  input  1  command byte offered.
REQ-007 iDATA  input  8  command byte to send to the device.
REQ-008 oREADY  output  1  block can accept a command.
REQ-009 oDONE  output  1  one-cycle pulse: byte sent and ACK received.
REQ-010 oERR  output  1  one-cycle pulse: transfer aborted.
REQ-011 oERR_CODE  output  2  valid with oERR: 01 timeout, 10 NACK (ACK bit high); holds last value otherwise.
REQ-012 ps2_clk_i, ps2_dat_i  input  1 each  raw PS/2 line levels.
REQ-013 ps2_clk_oe, ps2_dat_oe  output  1 each  1 = pull line low; 0 = release (open-drain, top level builds the inout).

Function
REQ-014 Each of ps2_clk_i and ps2_dat_i SHALL pass a 2-flop synchronizer, then a FILTER_LEN glitch filter; a clock falling edge SHALL be the filtered clock going 1->0.
REQ-015 Handshake: transfer accepted on the rising edge where iVALID && oREADY; iDATA latched then; oREADY SHALL be 1 only in IDLE; iVALID outside IDLE is ignored and not queued.
REQ-016 Parity bit SHALL be odd parity of the latched byte (XNOR-reduction of the 8 bits).
REQ-017 States: IDLE, INHIBIT, REQ, SEND, ACK_WAIT, RELEASE_WAIT, DONE, ERR.
REQ-018 IDLE: both oe = 0; on accept -> INHIBIT.
REQ-019 INHIBIT: ps2_clk_oe = 1, ps2_dat_oe = 0 for exactly INHIBIT_CYCLES cycles; then -> REQ.
REQ-020 REQ: ps2_dat_oe = 1 (start bit 0); ps2_clk_oe = 0; the first clock falling edge -> SEND with bit index 0.
REQ-021 SEND: on each falling edge the driven value SHALL advance to the next bit of D0..D7, parity, stop; data bit value b drives ps2_dat_oe = ~b; stop bit releases data (oe = 0).
REQ-022 The falling edge following the one that placed the stop bit SHALL move the block to ACK_WAIT; the falling edge seen in ACK_WAIT SHALL sample filtered data: 0 -> RELEASE_WAIT, 1 -> ERR with code 10.
REQ-023 RELEASE_WAIT: wait until filtered clock and data are both 1, then -> DONE.
REQ-024 DONE: oDONE = 1 for one cycle, then -> IDLE. ERR: oERR = 1 for one cycle, both oe = 0, then -> IDLE.
REQ-025 Timeout counter SHALL clear on entering REQ and on every falling edge; reaching TIMEOUT_CYCLES in REQ, SEND, ACK_WAIT or RELEASE_WAIT -> ERR with code 01.
REQ-026 Counter widths SHALL be sized with $clog2 of the parameters; no wrap-around before compare.
REQ-027 oDONE and oERR SHALL never both be 1 in the same cycle.

Reset
REQ-028 While iRST_n = 0, asynchronously: state IDLE, ps2_clk_oe = 0, ps2_dat_oe = 0, oDONE = 0, oERR = 0, oERR_CODE = 00, oREADY = 1 on the first clock after release, synchronizer/filter flops = 1, counters = 0.
REQ-029 Reset asserted mid-transfer SHALL release both lines in the same instant, without waiting for a clock edge; no oDONE/oERR pulse is produced for the aborted byte.

Verification
REQ-030 Reset check: hold iRST_n = 0 while ps2_clk_oe = 1 -> both oe = 0 immediately; after release oREADY = 1.
REQ-031 Send 0xF4, device BFM clocks at 12.5 kHz and ACKs -> ps2_clk_oe high for exactly 5000 cycles; BFM samples 0,0,0,1,0,1,1,1,1,0,1 (start, LSB first, parity 0, stop); one oDONE pulse, no oERR.
REQ-032 Send 0xFF -> parity bit sampled 1; oDONE pulse.
REQ-033 BFM never clocks after request -> oERR pulse with oERR_CODE = 01 exactly TIMEOUT_CYCLES after entering REQ; both lines released; oREADY = 1 next cycle.
REQ-034 BFM leaves data high at the ACK clock -> oERR, oERR_CODE = 10, no oDONE.
REQ-035 Pulse iVALID with 0xAA during SEND -> ignored and the original byte completes unchanged; assert iRST_n = 0 at bit 4 -> lines released asynchronously; then send 0xE8 -> completes with oDONE.
